// File: rtl/dptr_multiciclo.sv
// -----------------------------------------------------------------------------
// dptr_multiciclo
// Multi-cycle MIPS-subset processor core. It contains the datapath and the
// control FSM. A single memory port serves both instruction fetch and data
// access. The 32x32 register file, the ALU and the IR/MDR/A/B/ALUOut latches
// live here. The FSM steps through FETCH -> DECODE -> EXEC -> MEM -> WB.
//
// Memory handshake: while mem_re or mem_we is high, the request is pending.
// It completes in the cycle in which mem_ready=1. In that cycle mem_rdata is
// valid for reads and mem_wdata is committed for writes. While mem_ready=0,
// mem_addr/mem_re/mem_we/mem_wdata hold their values. mem_re and mem_we are
// never high together, and both are forced low while rst=1.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mem_addr   byte address (PC in FETCH, ALUOut in MEM)
//   mem_re     read request (FETCH, lw MEM)
//   mem_we     write request (sw MEM)
//   mem_wdata  store data (B latch)
//   mem_rdata  read data, valid when mem_ready=1
//   mem_ready  completes the pending request this cycle
//   pc_out     architectural PC
//   instr_out  IR contents
//   state_out  FSM state (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=7)
//   halt       high while in HALT
// -----------------------------------------------------------------------------
module dptr_multiciclo #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter bit          ENABLE_BNE      = 1'b1,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] mem_addr,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
   output logic [2:0]  state_out,
   output logic        halt
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   state_t      state, state_next;
   logic [31:0] pc, ir, mdr, a, b, alu_out;
   logic [31:0] regs [0:31];

   // instruction fields
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_sext;
   logic        unused_shamt;

   assign op           = ir[31:26];
   assign rs           = ir[25:21];
   assign rt           = ir[20:16];
   assign rd           = ir[15:11];
   assign funct        = ir[5:0];
   assign imm_sext     = {{16{ir[15]}}, ir[15:0]};
   assign unused_shamt = ^ir[10:6];

   // register file reads: R[0] is always zero
   logic [31:0] rd_a, rd_b;
   assign rd_a = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign rd_b = (rt == 5'd0) ? 32'd0 : regs[rt];

   logic funct_legal, op_legal;
   always_comb begin
      funct_legal = 1'b0;
      case (funct)
         6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A: funct_legal = 1'b1;
         default:                                 funct_legal = 1'b0;
      endcase
      op_legal = 1'b0;
      case (op)
         OP_R:                                 op_legal = funct_legal;
         OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW:  op_legal = 1'b1;
         OP_BNE:                               op_legal = ENABLE_BNE;
         default:                              op_legal = 1'b0;
      endcase
   end

   // R-type ALU
   logic [31:0] alu_r;
   always_comb begin
      alu_r = 32'd0;
      case (funct)
         6'h20:   alu_r = a + b;
         6'h22:   alu_r = a - b;
         6'h24:   alu_r = a & b;
         6'h25:   alu_r = a | b;
         6'h27:   alu_r = ~(a | b);
         6'h2A:   alu_r = {31'd0, $signed(a) < $signed(b)};
         default: alu_r = 32'd0;
      endcase
   end

   // write-back destination and source
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   always_comb begin
      wb_en   = 1'b0;
      wb_addr = 5'd0;
      wb_data = alu_out;
      case (op)
         OP_R:    begin wb_en = 1'b1; wb_addr = rd; end
         OP_ADDI: begin wb_en = 1'b1; wb_addr = rt; end
         OP_LW:   begin wb_en = 1'b1; wb_addr = rt; wb_data = mdr; end
         default: wb_en = 1'b0;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   // FSM: next state and memory request outputs
   always_comb begin
      state_next = state;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = pc;
      case (state)
         S_FETCH: begin
            mem_re = 1'b1;
            if (mem_ready) state_next = S_DECODE;
         end
         S_DECODE: begin
            if (!op_legal && HALT_ON_ILLEGAL) state_next = S_HALT;
            else                              state_next = S_EXEC;
         end
         S_EXEC: begin
            case (op)
               OP_R:         state_next = funct_legal ? S_WB : S_FETCH;
               OP_LW, OP_SW: state_next = S_MEM;
               OP_ADDI:      state_next = S_WB;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_addr = alu_out;
            mem_re   = (op == OP_LW);
            mem_we   = (op != OP_LW);
            if (mem_ready) state_next = (op == OP_LW) ? S_WB : S_FETCH;
         end
         S_WB:    state_next = S_FETCH;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
      // reset aborts any pending request immediately
      if (rst) begin
         mem_re = 1'b0;
         mem_we = 1'b0;
      end
   end

   // datapath latches and register file
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RESET_PC;
         ir      <= 32'd0;
         mdr     <= 32'd0;
         a       <= 32'd0;
         b       <= 32'd0;
         alu_out <= 32'd0;
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  ir <= mem_rdata;
                  pc <= pc + 32'd4;
               end
            end
            S_DECODE: begin
               a       <= rd_a;
               b       <= rd_b;
               // branch target computed early so EXEC only selects it
               alu_out <= pc + (imm_sext << 2);
            end
            S_EXEC: begin
               case (op)
                  OP_R:                  alu_out <= alu_r;
                  OP_LW, OP_SW, OP_ADDI: alu_out <= a + imm_sext;
                  OP_BEQ:                if (a == b) pc <= alu_out;
                  OP_BNE:                if (ENABLE_BNE && (a != b)) pc <= alu_out;
                  OP_J:                  pc <= {pc[31:28], ir[25:0], 2'b00};
                  default:               ;
               endcase
            end
            S_MEM: begin
               if (mem_ready && (op == OP_LW)) mdr <= mem_rdata;
            end
            S_WB: begin
               if (wb_en && (wb_addr != 5'd0)) regs[wb_addr] <= wb_data;
            end
            default: ;
         endcase
      end
   end

   assign mem_wdata = b;
   assign pc_out    = pc;
   assign instr_out = ir;
   assign state_out = state;
   assign halt      = (state == S_HALT);

endmodule

// File: tb/tb_dptr_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_dptr_multiciclo
// Directed test bench for dptr_multiciclo. It models the memory as a word array
// with a programmable wait count on data reads. It logs fetches and stores. It
// observes register contents through sw instructions that write them out.
// -----------------------------------------------------------------------------
module tb_dptr_multiciclo;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instr_out;
   logic        mem_re, mem_we, mem_ready, halt;
   logic [2:0]  state_out;

   dptr_multiciclo dut (
      .clk       (clk),
      .rst       (rst),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc_out    (pc_out),
      .instr_out (instr_out),
      .state_out (state_out),
      .halt      (halt)
   );

   // memory model
   logic [31:0] mem [0:255];
   int          data_wait = 0;
   int          wait_cnt  = 0;
   int          cur_wait;
   int          cyc = 0;

   assign cur_wait  = (mem_re && state_out == 3'd3) ? data_wait : 0;
   assign mem_ready = (mem_re || mem_we) && (wait_cnt >= cur_wait);
   assign mem_rdata = mem[mem_addr[9:2]];

   logic [31:0] st_addr_q[$], st_data_q[$], fetch_addr_q[$];
   int          fetch_cyc_q[$];
   logic [31:0] exp_q[$], exp_addr_q[$];

   int checks = 0;
   int errors = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst || !(mem_re || mem_we) || mem_ready) wait_cnt <= 0;
      else                                         wait_cnt <= wait_cnt + 1;
      if (!rst && mem_we && mem_ready) begin
         mem[mem_addr[9:2]] <= mem_wdata;
         st_addr_q.push_back(mem_addr);
         st_data_q.push_back(mem_wdata);
      end
      if (!rst && mem_re && mem_ready && state_out == 3'd0) begin
         fetch_addr_q.push_back(mem_addr);
         fetch_cyc_q.push_back(cyc);
      end
   end

   // instruction encoders
   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction
   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] enc_j(input logic [25:0] t);
      return {6'h02, t};
   endfunction
   localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

   // driver tasks
   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
   endtask

   task automatic clear_logs();
      st_addr_q.delete();
      st_data_q.delete();
      fetch_addr_q.delete();
      fetch_cyc_q.delete();
      exp_q.delete();
      exp_addr_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      data_wait = 0;
      clear_logs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_to_halt(input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (halt) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      clear_mem();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_req got re=%b we=%b exp re=0 we=0", mem_re, mem_we);
      end
      checks++;
      if (halt !== 1'b0 || instr_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_halt_ir got halt=%b ir=%h exp halt=0 ir=0", halt, instr_out);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (pc_out !== 32'd0 || state_out !== 3'd0) begin
         errors++;
         $display("FAIL reset_pc_state got pc=%h st=%0d exp pc=0 st=0", pc_out, state_out);
      end
      checks++;
      if (mem_re !== 1'b1 || mem_addr !== 32'd0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_fetch got re=%b we=%b addr=%h exp re=1 we=0 addr=0",
                  mem_re, mem_we, mem_addr);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_rtype();
      bit ok;
      clear_mem();
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
      mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
      mem[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
      mem[4] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0200);
      mem[5] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0204);
      mem[6] = ILLEGAL;
      do_reset();
      run_to_halt(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rtype_halt got timeout exp halt");
      end
      exp_addr_q.push_back(32'h200); exp_q.push_back(32'd2);
      exp_addr_q.push_back(32'h204); exp_q.push_back(32'd1);
      checks++;
      if (st_data_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rtype_store_count got %0d exp %0d", st_data_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= st_data_q.size() || st_data_q[i] !== exp_q[i] || st_addr_q[i] !== exp_addr_q[i]) begin
            errors++;
            $display("FAIL rtype_store%0d got %h@%h exp %h@%h", i,
                     (i < st_data_q.size()) ? st_data_q[i] : 32'hx,
                     (i < st_addr_q.size()) ? st_addr_q[i] : 32'hx, exp_q[i], exp_addr_q[i]);
         end
      end
      checks++;
      if (fetch_cyc_q.size() < 4 || (fetch_cyc_q[3] - fetch_cyc_q[2]) != 4) begin
         errors++;
         $display("FAIL rtype_add_cpi got %0d exp 4",
                  (fetch_cyc_q.size() < 4) ? -1 : fetch_cyc_q[3] - fetch_cyc_q[2]);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_memory();
      bit ok, found;
      clear_mem();
      mem[0] = enc_j(26'h4);
      mem[4] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
      mem[5] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
      mem[6] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
      mem[7] = enc_i(6'h2B, 5'd0, 5'd5, 16'd12);
      mem[8] = ILLEGAL;
      do_reset();
      data_wait = 3;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (state_out == 3'd3 && mem_re) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mem_lw_reach got timeout exp lw in MEM");
      end
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd8 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL mem_lw_hold%0d got re=%b we=%b addr=%h rdy=%b exp re=1 we=0 addr=8 rdy=0",
                     i, mem_re, mem_we, mem_addr, mem_ready);
         end
      end
      run_to_halt(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL mem_halt got timeout exp halt");
      end
      exp_addr_q.push_back(32'h8); exp_q.push_back(32'd2);
      exp_addr_q.push_back(32'hC); exp_q.push_back(32'd2);
      checks++;
      if (st_data_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL mem_store_count got %0d exp %0d", st_data_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= st_data_q.size() || st_data_q[i] !== exp_q[i] || st_addr_q[i] !== exp_addr_q[i]) begin
            errors++;
            $display("FAIL mem_store%0d got %h@%h exp %h@%h", i,
                     (i < st_data_q.size()) ? st_data_q[i] : 32'hx,
                     (i < st_addr_q.size()) ? st_addr_q[i] : 32'hx, exp_q[i], exp_addr_q[i]);
         end
      end
      checks++;
      if (fetch_cyc_q.size() < 5 || (fetch_cyc_q[3] - fetch_cyc_q[2]) != 4) begin
         errors++;
         $display("FAIL mem_sw_cpi got %0d exp 4",
                  (fetch_cyc_q.size() < 5) ? -1 : fetch_cyc_q[3] - fetch_cyc_q[2]);
      end
      checks++;
      if (fetch_cyc_q.size() < 5 || (fetch_cyc_q[4] - fetch_cyc_q[3]) != 8) begin
         errors++;
         $display("FAIL mem_lw_cpi got %0d exp 8",
                  (fetch_cyc_q.size() < 5) ? -1 : fetch_cyc_q[4] - fetch_cyc_q[3]);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_branch_jump();
      bit ok;
      logic [31:0] exp_fetch [0:8];
      clear_mem();
      mem[0]    = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
      mem[1]    = enc_i(6'h08, 5'd0, 5'd0, 16'd0);
      mem[2]    = enc_i(6'h08, 5'd0, 5'd0, 16'd0);
      mem[3]    = enc_i(6'h08, 5'd0, 5'd0, 16'd0);
      mem[4]    = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
      mem[5]    = ILLEGAL;
      mem[6]    = ILLEGAL;
      mem[7]    = enc_i(6'h05, 5'd1, 5'd1, 16'd5);
      mem[8]    = enc_j(26'h40);
      mem[9]    = ILLEGAL;
      mem[8'h40] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0204);
      mem[8'h41] = ILLEGAL;
      exp_fetch = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h1C, 32'h20, 32'h100, 32'h104};
      do_reset();
      run_to_halt(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL br_halt got timeout exp halt");
      end
      checks++;
      if (fetch_addr_q.size() != 9) begin
         errors++;
         $display("FAIL br_fetch_count got %0d exp 9", fetch_addr_q.size());
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (i >= fetch_addr_q.size() || fetch_addr_q[i] !== exp_fetch[i]) begin
            errors++;
            $display("FAIL br_fetch%0d got %h exp %h", i,
                     (i < fetch_addr_q.size()) ? fetch_addr_q[i] : 32'hx, exp_fetch[i]);
         end
      end
      checks++;
      if (fetch_cyc_q.size() < 8 || (fetch_cyc_q[5] - fetch_cyc_q[4]) != 3 ||
          (fetch_cyc_q[7] - fetch_cyc_q[6]) != 3) begin
         errors++;
         $display("FAIL br_cpi got beq=%0d j=%0d exp 3 3",
                  (fetch_cyc_q.size() < 8) ? -1 : fetch_cyc_q[5] - fetch_cyc_q[4],
                  (fetch_cyc_q.size() < 8) ? -1 : fetch_cyc_q[7] - fetch_cyc_q[6]);
      end
      checks++;
      if (st_data_q.size() != 1 || st_data_q[0] !== 32'd1 || st_addr_q[0] !== 32'h204) begin
         errors++;
         $display("FAIL br_store got n=%0d data=%h exp n=1 data=1@204", st_data_q.size(),
                  (st_data_q.size() > 0) ? st_data_q[0] : 32'hx);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_zero_wrap();
      bit ok;
      clear_mem();
      mem[0]     = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
      mem[1]     = enc_i(6'h2B, 5'd0, 5'd0, 16'h0200);
      mem[2]     = enc_i(6'h23, 5'd0, 5'd1, 16'h0300);
      mem[3]     = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
      mem[4]     = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
      mem[5]     = enc_i(6'h2B, 5'd0, 5'd3, 16'h0204);
      mem[6]     = enc_r(5'd0, 5'd2, 5'd4, 6'h22);
      mem[7]     = enc_i(6'h2B, 5'd0, 5'd4, 16'h0208);
      mem[8]     = enc_r(5'd1, 5'd2, 5'd5, 6'h24);
      mem[9]     = enc_i(6'h2B, 5'd0, 5'd5, 16'h020C);
      mem[10]    = enc_r(5'd1, 5'd2, 5'd6, 6'h25);
      mem[11]    = enc_i(6'h2B, 5'd0, 5'd6, 16'h0210);
      mem[12]    = enc_r(5'd0, 5'd2, 5'd7, 6'h27);
      mem[13]    = enc_i(6'h2B, 5'd0, 5'd7, 16'h0214);
      mem[14]    = enc_r(5'd1, 5'd3, 5'd8, 6'h2A);
      mem[15]    = enc_i(6'h2B, 5'd0, 5'd8, 16'h0218);
      mem[16]    = ILLEGAL;
      mem[8'hC0] = 32'h7FFF_FFFF;
      do_reset();
      run_to_halt(400, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wrap_halt got timeout exp halt");
      end
      checks++;
      if (pc_out !== 32'h44 || state_out !== 3'd7) begin
         errors++;
         $display("FAIL wrap_halt_pc got pc=%h st=%0d exp pc=44 st=7", pc_out, state_out);
      end
      exp_addr_q.push_back(32'h200); exp_q.push_back(32'h0000_0000);
      exp_addr_q.push_back(32'h204); exp_q.push_back(32'h8000_0000);
      exp_addr_q.push_back(32'h208); exp_q.push_back(32'hFFFF_FFFF);
      exp_addr_q.push_back(32'h20C); exp_q.push_back(32'h0000_0001);
      exp_addr_q.push_back(32'h210); exp_q.push_back(32'h7FFF_FFFF);
      exp_addr_q.push_back(32'h214); exp_q.push_back(32'hFFFF_FFFE);
      exp_addr_q.push_back(32'h218); exp_q.push_back(32'h0000_0000);
      checks++;
      if (st_data_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL wrap_store_count got %0d exp %0d", st_data_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= st_data_q.size() || st_data_q[i] !== exp_q[i] || st_addr_q[i] !== exp_addr_q[i]) begin
            errors++;
            $display("FAIL wrap_store%0d got %h@%h exp %h@%h", i,
                     (i < st_data_q.size()) ? st_data_q[i] : 32'hx,
                     (i < st_addr_q.size()) ? st_addr_q[i] : 32'hx, exp_q[i], exp_addr_q[i]);
         end
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_illegal_reset();
      bit ok, found, bad;
      clear_mem();
      mem[0] = ILLEGAL;
      do_reset();
      run_to_halt(20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ill_halt got timeout exp halt");
      end
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_re !== 1'b0 || mem_we !== 1'b0 || pc_out !== 32'd4 || halt !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL ill_frozen got re=%b we=%b pc=%h halt=%b exp re=0 we=0 pc=4 halt=1",
                  mem_re, mem_we, pc_out, halt);
      end

      // reset during a stalled lw
      clear_mem();
      mem[0]     = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
      mem[1]     = enc_i(6'h23, 5'd0, 5'd1, 16'h0300);
      mem[8'hC0] = 32'h55;
      do_reset();
      data_wait = 20;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (state_out == 3'd3 && mem_re) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rst_lw_reach got timeout exp lw in MEM");
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL rst_abort_req got re=%b we=%b exp re=0 we=0", mem_re, mem_we);
      end
      @(negedge clk);
      checks++;
      if (pc_out !== 32'd0 || state_out !== 3'd0) begin
         errors++;
         $display("FAIL rst_abort_pc got pc=%h st=%0d exp pc=0 st=0", pc_out, state_out);
      end
      mem[0] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0200);
      mem[1] = ILLEGAL;
      data_wait = 0;
      clear_logs();
      @(negedge clk);
      rst = 1'b0;
      run_to_halt(100, ok);
      checks++;
      if (!ok || st_data_q.size() != 1 || st_data_q[0] !== 32'd0 || st_addr_q[0] !== 32'h200) begin
         errors++;
         $display("FAIL rst_reg1 got ok=%b n=%0d data=%h exp ok=1 n=1 data=0@200", ok,
                  st_data_q.size(), (st_data_q.size() > 0) ? st_data_q[0] : 32'hx);
      end
   endtask

   // -------------------------------------------------------------------------
   initial begin
      clear_mem();
      test_reset();
      test_rtype();
      test_memory();
      test_branch_jump();
      test_zero_wrap();
      test_illegal_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
